// File: rtl/hbus_arbiter4.sv
// hbus_arbiter4: round-robin arbiter and sequencer for a shared 4-way 16-bit mux path.
// Define ARB_TIMEOUT_EN to force release of a grant whose consumer stalls for TIMEOUT cycles.
module hbus_arbiter4 #(
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  last,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_c,
  input  logic [15:0] in_d,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [3:0]  grant,
  output logic [1:0]  sel,
  output logic        busy,
  output logic        timeout
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t      state_p0, state_nx;
  logic [1:0]  ptr_p0, ptr_nx;
  logic [1:0]  sel_p0, sel_nx;
  logic [3:0]  grant_p0, grant_nx;
  logic [3:0]  beat_p0, beat_nx;
  logic [1:0]  win_c;
  logic        vld_p0;
  logic        beat_done;
  logic        release_c;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  logic [15:0] stall_p0, stall_nx;
  logic        tmo_p0, tmo_nx;
  logic        tmo_hit;
`else
  logic        unused_tmo;
  assign unused_tmo = (TIMEOUT == 0);
`endif

  // First requester found scanning p, p+1, ... (mod 4); the nearest offset wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign win_c = rr_pick(req, ptr_p0);

  // Stage p0: next-state and next control values
  always_comb begin
    state_nx  = state_p0;
    ptr_nx    = ptr_p0;
    sel_nx    = sel_p0;
    grant_nx  = grant_p0;
    beat_nx   = beat_p0;
    beat_done = vld_p0 & out_ready;
    release_c = 1'b0;
`ifdef ARB_TIMEOUT_EN
    stall_nx  = stall_p0;
    tmo_nx    = 1'b0;
    tmo_hit   = 1'b0;
`endif
    case (state_p0)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          sel_nx   = win_c;
          grant_nx = 4'b0001 << win_c;
          ptr_nx   = win_c + 2'd1;
          beat_nx  = '0;
`ifdef ARB_TIMEOUT_EN
          stall_nx = '0;
`endif
        end
      end
      GRANT: begin
        if (beat_done) beat_nx = beat_p0 + 4'd1;
`ifdef ARB_TIMEOUT_EN
        if (beat_done) begin
          stall_nx = '0;
        end else if (vld_p0) begin
          stall_nx = stall_p0 + 16'd1;
          tmo_hit  = (stall_nx == TMO);
        end
`endif
        release_c = !req[sel_p0] | (beat_done & (last[sel_p0] | (beat_nx == MAX_B)));
`ifdef ARB_TIMEOUT_EN
        release_c = release_c | tmo_hit;
`endif
        if (release_c) begin
          state_nx = IDLE;
          grant_nx = '0;
`ifdef ARB_TIMEOUT_EN
          tmo_nx   = tmo_hit;
`endif
        end
      end
      default: ;
    endcase
  end

  // Stage p0 register: all state here is control, so all of it resets
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      ptr_p0   <= '0;
      sel_p0   <= '0;
      grant_p0 <= '0;
      beat_p0  <= '0;
`ifdef ARB_TIMEOUT_EN
      stall_p0 <= '0;
      tmo_p0   <= 1'b0;
`endif
    end else begin
      state_p0 <= state_nx;
      ptr_p0   <= ptr_nx;
      sel_p0   <= sel_nx;
      grant_p0 <= grant_nx;
      beat_p0  <= beat_nx;
`ifdef ARB_TIMEOUT_EN
      stall_p0 <= stall_nx;
      tmo_p0   <= tmo_nx;
`endif
    end
  end

  // Output stage: combinational valid and data mux driven by the registered select
  always_comb begin
    vld_p0   = (state_p0 == GRANT) & req[sel_p0];
    out_data = in_a;
    case (sel_p0)
      2'd0: out_data = in_a;
      2'd1: out_data = in_b;
      2'd2: out_data = in_c;
      2'd3: out_data = in_d;
      default: out_data = in_a;
    endcase
  end

  assign out_valid = vld_p0;
  assign grant     = grant_p0;
  assign sel       = sel_p0;
  assign busy      = (state_p0 == GRANT);
`ifdef ARB_TIMEOUT_EN
  assign timeout   = tmo_p0;
`else
  assign timeout   = 1'b0;
`endif

endmodule
